// File: rtl/module_idiv_seq_if.sv
// Start/done handshake and result bus for the iterative divider.
//   master: drives start, dividend, divisor; observes busy/done and the results
//   slave : the divider itself
interface idiv_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/module_idiv_seq.sv
// Iterative restoring integer divider, one quotient bit per clock.
// Ports:
//   clk   - clock, all state updates on posedge
//   rst_n - asynchronous active-low reset
//   bus   - idiv_if.slave: start/dividend/divisor in; busy, done (1-cycle
//           pulse), quotient, remainder, div_by_zero out (held until next result)
// Build option: define IDIV_SIGNED_EN for two's-complement operands
// (truncating division, remainder takes the dividend sign).
module module_idiv_seq #(
    parameter int unsigned WIDTH = 16
) (
    input logic   clk,
    input logic   rst_n,
    idiv_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dsr_q;
    logic [CNT_W-1:0] cnt;
    logic             dbz_q;

    logic [WIDTH:0]   shift_c;
    logic [WIDTH:0]   diff_c;
    logic             ge_c;
    logic [WIDTH-1:0] dvd_mag_c;
    logic [WIDTH-1:0] dsr_mag_c;
    logic [WIDTH-1:0] quo_fix_c;
    logic [WIDTH-1:0] rem_fix_c;

`ifdef IDIV_SIGNED_EN
    logic quo_neg_q;
    logic dvd_neg_q;
`endif

    // One restoring step: the partial remainder is WIDTH+1 bits wide, so the
    // borrow out of the subtraction is exactly "shifted < divisor".
    always_comb begin
        shift_c = {rem_q, quo_q[WIDTH-1]};
        diff_c  = shift_c - {1'b0, dsr_q};
        ge_c    = ~diff_c[WIDTH];
    end

    // Operand magnitudes at capture and sign fix-up of the finished result.
    always_comb begin
`ifdef IDIV_SIGNED_EN
        dvd_mag_c = bus.dividend[WIDTH-1] ? (~bus.dividend) + WIDTH'(1) : bus.dividend;
        dsr_mag_c = bus.divisor[WIDTH-1]  ? (~bus.divisor)  + WIDTH'(1) : bus.divisor;
        if (dbz_q) begin
            // quo_q still holds |dividend|; restore the dividend as given
            quo_fix_c = '1;
            rem_fix_c = dvd_neg_q ? (~quo_q) + WIDTH'(1) : quo_q;
        end else begin
            quo_fix_c = quo_neg_q ? (~quo_q) + WIDTH'(1) : quo_q;
            rem_fix_c = dvd_neg_q ? (~rem_q) + WIDTH'(1) : rem_q;
        end
`else
        dvd_mag_c = bus.dividend;
        dsr_mag_c = bus.divisor;
        if (dbz_q) begin
            quo_fix_c = '1;
            rem_fix_c = quo_q;
        end else begin
            quo_fix_c = quo_q;
            rem_fix_c = rem_q;
        end
`endif
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            rem_q           <= '0;
            quo_q           <= '0;
            dsr_q           <= '0;
            cnt             <= '0;
            dbz_q           <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.quotient    <= '0;
            bus.remainder   <= '0;
            bus.div_by_zero <= 1'b0;
`ifdef IDIV_SIGNED_EN
            quo_neg_q       <= 1'b0;
            dvd_neg_q       <= 1'b0;
`endif
        end else begin
            // Results publish one edge after DONE is entered, together with the pulse.
            bus.done <= (state == DONE);
            if (state == DONE) begin
                bus.quotient    <= quo_fix_c;
                bus.remainder   <= rem_fix_c;
                bus.div_by_zero <= dbz_q;
            end

            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        rem_q <= '0;
                        quo_q <= dvd_mag_c;
                        dsr_q <= dsr_mag_c;
                        cnt   <= '0;
                        dbz_q <= (dsr_mag_c == '0);
`ifdef IDIV_SIGNED_EN
                        quo_neg_q <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                        dvd_neg_q <= bus.dividend[WIDTH-1];
`endif
                        if (dsr_mag_c == '0) begin
                            state    <= DONE;
                            bus.busy <= 1'b0;
                        end else begin
                            state    <= CALC;
                            bus.busy <= 1'b1;
                        end
                    end else begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end
                end
                CALC: begin
                    rem_q <= ge_c ? diff_c[WIDTH-1:0] : shift_c[WIDTH-1:0];
                    quo_q <= {quo_q[WIDTH-2:0], ge_c};
                    cnt   <= cnt + CNT_W'(1);
                    if (cnt == LAST_ITER) begin
                        state    <= DONE;
                        bus.busy <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_module_idiv_seq.sv
module tb_module_idiv_seq;
    localparam int unsigned W = 16;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } vec_t;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
        int           due;
        int           id;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;
    int   busy_cnt;
    int   next_id;
    logic [W-1:0] last_q;
    exp_t sb[$];
    vec_t vecs[$];

    idiv_if #(.WIDTH(W)) bus ();

    module_idiv_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (bus.busy) busy_cnt++;

    task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (op %0d): got %0h expected %0h", name, id, act, exp);
        end
    endtask

    // Reference model, independent of the shift/subtract implementation.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int   sa;
        int   sb_v;
        e.due = 0;
        e.id  = 0;
        if (b == '0) begin
            e.q = '1;
            e.r = a;
            e.z = 1'b1;
        end else begin
`ifdef IDIV_SIGNED_EN
            sa   = int'($signed(a));
            sb_v = int'($signed(b));
            e.q  = W'(sa / sb_v);
            e.r  = W'(sa % sb_v);
`else
            sa   = int'({16'd0, a});
            sb_v = int'({16'd0, b});
            e.q  = W'(sa / sb_v);
            e.r  = W'(sa % sb_v);
`endif
            e.z = 1'b0;
        end
        return e;
    endfunction

    // Drive one start pulse at the next negedge; optionally expect a result.
    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] q, input logic [W-1:0] r,
                           input logic z, input bit expect_it);
        exp_t e;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        if (expect_it) begin
            e.q   = q;
            e.r   = r;
            e.z   = z;
            e.due = cyc + 1 + ((b == '0) ? 1 : W + 1);
            e.id  = next_id++;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.dividend = $urandom_range(16'hFFFF, 0);
        bus.divisor  = $urandom_range(16'hFFFF, 0);
    endtask

    task automatic wait_drain(input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            #1;
            if (sb.size() == 0) break;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: %0d results pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_done: got done=1 expected 0 at cycle %0d", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("quotient", e.id, 32'(bus.quotient), 32'(e.q));
                chk("remainder", e.id, 32'(bus.remainder), 32'(e.r));
                chk("div_by_zero", e.id, 32'(bus.div_by_zero), 32'(e.z));
                chk("latency", e.id, 32'(cyc), 32'(e.due));
                last_q = e.q;
            end
        end
    end

    initial begin
        vec_t v;
        exp_t m;
        cyc = 0; checks = 0; errors = 0; busy_cnt = 0; next_id = 0; last_q = '0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.dividend = '0;
        bus.divisor = '0;

`ifdef IDIV_SIGNED_EN
        vecs.push_back('{16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0});
        vecs.push_back('{16'h0007, 16'hFFFE, 16'hFFFD, 16'h0001, 1'b0});
        vecs.push_back('{16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0});
        vecs.push_back('{16'h8000, 16'h0001, 16'h8000, 16'h0000, 1'b0});
        vecs.push_back('{16'hFFF9, 16'hFFFE, 16'h0003, 16'hFFFF, 1'b0});
        vecs.push_back('{16'hFB2E, 16'h0000, 16'hFFFF, 16'hFB2E, 1'b1});
        vecs.push_back('{16'd9,    16'd3,    16'd3,    16'd0,    1'b0});
`else
        vecs.push_back('{16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0});
        vecs.push_back('{16'h0005, 16'h0009, 16'h0000, 16'h0005, 1'b0});
        vecs.push_back('{16'd1234, 16'd0,    16'hFFFF, 16'd1234, 1'b1});
        vecs.push_back('{16'd9,    16'd3,    16'd3,    16'd0,    1'b0});
        vecs.push_back('{16'h0000, 16'h0005, 16'h0000, 16'h0000, 1'b0});
        vecs.push_back('{16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000, 1'b0});
        vecs.push_back('{16'h8000, 16'h0003, 16'h2AAA, 16'h0002, 1'b0});
        vecs.push_back('{16'hFFFE, 16'h8000, 16'h0001, 16'h7FFE, 1'b0});
`endif

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_busy", -1, 32'(bus.busy), 32'd0);
        chk("rst_done", -1, 32'(bus.done), 32'd0);
        chk("rst_quotient", -1, 32'(bus.quotient), 32'd0);
        chk("rst_remainder", -1, 32'(bus.remainder), 32'd0);
        chk("rst_div_by_zero", -1, 32'(bus.div_by_zero), 32'd0);
        rst_n = 1'b1;

        // 100/7 with busy-length measurement
        busy_cnt = 0;
        run_div(16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 1'b1);
        wait_drain(40);
        chk("busy_cycles", -1, 32'(busy_cnt), 32'd16);

        // Table of fixed vectors
        foreach (vecs[i]) begin
            v = vecs[i];
            run_div(v.a, v.b, v.q, v.r, v.z, 1'b1);
            wait_drain(40);
        end

        // Results hold through idle
        repeat (3) @(negedge clk);
        chk("hold_idle", -1, 32'(bus.quotient), 32'(last_q));

        // Start pulsed mid-calculation is ignored
        m = model(16'd1000, 16'd10);
        run_div(16'd1000, 16'd10, m.q, m.r, m.z, 1'b1);
        repeat (5) @(posedge clk);
        run_div(16'd50, 16'd5, '0, '0, 1'b0, 1'b0);
        wait_drain(40);

        // Back-to-back accept from the DONE state: no idle gap
        m = model(16'd1000, 16'd10);
        run_div(16'd1000, 16'd10, m.q, m.r, m.z, 1'b1);
        repeat (16) @(posedge clk);
        m = model(16'd200, 16'd7);
        run_div(16'd200, 16'd7, m.q, m.r, m.z, 1'b1);
        @(negedge clk);
        chk("b2b_busy", -1, 32'(bus.busy), 32'd1);
        wait_drain(40);

        // Reset in the middle of a calculation aborts it
        run_div(16'd1000, 16'd10, '0, '0, 1'b0, 1'b0);
        repeat (8) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", -1, 32'(bus.busy), 32'd0);
        chk("abort_quotient", -1, 32'(bus.quotient), 32'd0);
        chk("abort_remainder", -1, 32'(bus.remainder), 32'd0);
        chk("abort_div_by_zero", -1, 32'(bus.div_by_zero), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        run_div(16'd81, 16'd9, 16'd9, 16'd0, 1'b0, 1'b1);
        wait_drain(40);

        // Random operands against the model, some with zero divisor
        for (int i = 0; i < 24; i++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            a = W'($urandom_range(16'hFFFF, 0));
            b = (i % 6 == 5) ? '0 : W'($urandom_range(16'hFFFF, 0));
            if (i % 4 == 1) b = W'($urandom_range(16'h00FF, 1));
            m = model(a, b);
            run_div(a, b, m.q, m.r, m.z, 1'b1);
            wait_drain(40);
        end

        repeat (25) @(negedge clk);
        chk("scoreboard_empty", -1, 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
